sa_cell_ctrl: RTL and testbench

- Sequencer for a single systolic-array MAC cell. Each job has three phases:
  - Accepts a job: a weight plus a beat count.
  - Loads the weight into the cell, clears the cell accumulator, then streams exactly N activations into the cell under a valid/ready handshake.
  - Waits out the cell's one-cycle MAC latency, then presents the captured partial sum on a result valid/ready port.
- Sits between the array feeder/scheduler and one cell. The cell stays purely a datapath.

---
 rtl/sa_pkg.sv | 8 +
 rtl/sa_cell_ctrl_if.sv | 25 ++
 rtl/sa_beat_counter.sv | 24 ++
 rtl/sa_cell_ctrl.sv | 57 +++++
 tb/tb_sa_cell_ctrl.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/sa_pkg.sv
// sa_pkg: shared state encoding, operand-width defaults and cell latency for the systolic cell controller
package sa_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF = 24;
  localparam int K_MAX_DEF = 256;
  localparam int CELL_LAT = 1;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, FLUSH, DONE} state_t;
endpackage

// File: rtl/sa_cell_ctrl_if.sv
// sa_cell_ctrl_if: job, activation, cell and result ports between a feeder/consumer and the cell controller
interface sa_cell_ctrl_if import sa_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = $clog2(K_MAX_DEF + 1)
);
  logic cfg_valid, cfg_ready;
  logic [CNT_W-1:0] cfg_len;
  logic [DATA_W-1:0] cfg_weight;
  logic act_valid, act_ready;
  logic [DATA_W-1:0] act_data;
  logic cell_w_load, cell_acc_clr, cell_en;
  logic [DATA_W-1:0] cell_w_data, cell_a_data;
  logic [ACC_W-1:0] cell_psum;
  logic res_valid, res_ready;
  logic [ACC_W-1:0] res_data;
  modport master (
    input cfg_valid, cfg_len, cfg_weight, act_valid, act_data, cell_psum, res_ready,
    output cfg_ready, act_ready, cell_w_load, cell_w_data, cell_acc_clr, cell_en, cell_a_data, res_valid, res_data
  );
  modport slave (
    output cfg_valid, cfg_len, cfg_weight, act_valid, act_data, cell_psum, res_ready,
    input cfg_ready, act_ready, cell_w_load, cell_w_data, cell_acc_clr, cell_en, cell_a_data, res_valid, res_data
  );
endinterface

// File: rtl/sa_beat_counter.sv
// sa_beat_counter: counts accepted beats against a latched job length and flags the final handshake
module sa_beat_counter #(
  parameter int CNT_W = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clr,
  input  logic inc,
  input  logic [CNT_W-1:0] len,
  output logic last
);
  logic [CNT_W-1:0] cnt, len_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      len_q <= '0;
    end else begin
      if (load) len_q <= len;
      cnt <= (load || clr) ? '0 : inc ? cnt + 1'b1 : cnt;
    end
  end
  assign last = inc && cnt == len_q - 1'b1;
endmodule

// File: rtl/sa_cell_ctrl.sv
// sa_cell_ctrl: sequences one MAC cell through weight load, N activation beats, flush and result handoff
module sa_cell_ctrl import sa_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int K_MAX = K_MAX_DEF,
  parameter int CNT_W = $clog2(K_MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  sa_cell_ctrl_if.master bus,
  output logic busy,
  output logic err_zero_len
);
  state_t state, state_n;
  logic [DATA_W-1:0] w_q;
  logic [ACC_W-1:0] res_q;
  logic err_q, cfg_hs, act_hs, zero_len, last;
  assign zero_len = bus.cfg_len == '0;
  assign cfg_hs = bus.cfg_valid && bus.cfg_ready;
  assign act_hs = bus.act_valid && bus.act_ready;
  sa_beat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk(clk), .rst(rst), .load(cfg_hs && !zero_len), .clr(state == LOAD),
    .inc(act_hs), .len(bus.cfg_len), .last(last)
  );
  always_comb begin
    state_n = state == IDLE  ? (cfg_hs && !zero_len ? LOAD : IDLE)
            : state == LOAD  ? RUN
            : state == RUN   ? (act_hs && last ? FLUSH : RUN)
            : state == FLUSH ? DONE
            : (bus.res_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      w_q <= '0;
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      err_q <= cfg_hs && zero_len;
      if (cfg_hs) w_q <= bus.cfg_weight;
      if (state == FLUSH) res_q <= bus.cell_psum;
    end
  end
  // rst forces every output low immediately, before the state register sees it
  assign bus.cfg_ready = !rst && state == IDLE;
  assign bus.act_ready = !rst && state == RUN;
  assign bus.cell_w_load = !rst && state == LOAD;
  assign bus.cell_acc_clr = !rst && state == LOAD;
  assign bus.cell_w_data = (!rst && state == LOAD) ? w_q : '0;
  assign bus.cell_en = act_hs;
  assign bus.cell_a_data = act_hs ? bus.act_data : '0;
  assign bus.res_valid = !rst && state == DONE;
  assign bus.res_data = rst ? '0 : res_q;
  assign busy = !rst && state != IDLE;
  assign err_zero_len = !rst && err_q;
endmodule

// File: tb/tb_sa_cell_ctrl.sv
// tb_sa_cell_ctrl: directed and randomized jobs against a behavioural cell and a sum-of-products reference
module tb_sa_cell_ctrl;
  logic clk = 0, rst = 1;
  logic busy, err;
  int checks = 0, failures = 0, cyc = 0;
  int en_cnt = 0, busy_cnt = 0, rv_cnt = 0, wl_cnt = 0;
  int d_en, d_busy, d_rv, d_wl, t0, t1;
  logic [7:0] cw = 0;
  logic [23:0] psum = 0;
  logic [7:0] acts[$];

  sa_cell_ctrl_if #(.DATA_W(8), .ACC_W(24), .CNT_W(9)) bus();
  sa_cell_ctrl dut (.clk(clk), .rst(rst), .bus(bus), .busy(busy), .err_zero_len(err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bus.cell_w_load) cw <= bus.cell_w_data;
    if (bus.cell_acc_clr) psum <= '0;
    else if (bus.cell_en) psum <= psum + {16'b0, cw} * {16'b0, bus.cell_a_data};
  end
  assign bus.cell_psum = psum;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (bus.cell_en) en_cnt++;
    if (busy) busy_cnt++;
    if (bus.res_valid) rv_cnt++;
    if (bus.cell_w_load) wl_cnt++;
    chk("strobe_excl", 32'(bus.cell_en && (bus.cell_w_load || bus.cell_acc_clr)), 0);
    chk("w_data_idle", 32'(!bus.cell_w_load && bus.cell_w_data != 0), 0);
    chk("a_data_idle", 32'(!bus.cell_en && bus.cell_a_data != 0), 0);
  end

  task automatic chk_quiet(input string tag);
    chk({tag, "_ctl"}, 32'({bus.cfg_ready, bus.act_ready, bus.cell_w_load, bus.cell_acc_clr,
                            bus.cell_en, bus.res_valid, busy, err}), 0);
    chk({tag, "_data"}, 32'({bus.cell_w_data, bus.cell_a_data}), 0);
    chk({tag, "_res"}, 32'(bus.res_data), 0);
  endtask

  task automatic accept(input logic [7:0] w, input int len);
    int n;
    n = 0;
    bus.cfg_valid = 1; bus.cfg_weight = w; bus.cfg_len = 9'(len);
    #1;
    while (!bus.cfg_ready && n < 20) begin @(negedge clk); #1; n++; end
    chk("cfg_accept", 32'(bus.cfg_ready), 1);
    t0 = cyc;
    @(negedge clk);
    bus.cfg_valid = 0;
  endtask

  task automatic feed(input int gap, input bit rnd);
    for (int i = 0; i < acts.size(); i++) begin
      int g, n;
      g = rnd ? int'($urandom_range(0, 2)) : gap;
      n = 0;
      if (i > 0) repeat (g) begin bus.act_valid = 0; bus.act_data = 8'($urandom); @(negedge clk); end
      bus.act_valid = 1; bus.act_data = acts[i];
      #1;
      while (!bus.act_ready && n < 20) begin @(negedge clk); #1; n++; end
      chk("act_ready", 32'(bus.act_ready), 1);
      @(negedge clk);
    end
    bus.act_valid = 0; bus.act_data = 0;
  endtask

  task automatic finish(input logic [23:0] exp, input int stall, input bit probe);
    int n;
    n = 0;
    bus.res_ready = 0;
    #1;
    while (!bus.res_valid && n < 20) begin @(negedge clk); #1; n++; end
    chk("res_valid", 32'(bus.res_valid), 1);
    if (probe) begin bus.cfg_valid = 1; bus.cfg_len = 0; bus.cfg_weight = 8'h5a; end
    for (int s = 0; s < stall; s++) begin
      chk("hold_valid", 32'(bus.res_valid), 1);
      chk("hold_data", 32'(bus.res_data), 32'(exp));
      if (probe) chk("cfg_blocked", 32'({bus.cfg_ready, err}), 0);
      @(negedge clk); #1;
    end
    bus.res_ready = 1;
    chk("res_data", 32'(bus.res_data), 32'(exp));
    t1 = cyc;
    @(negedge clk);
    bus.res_ready = 0;
    #1;
    chk("res_drop", 32'(bus.res_valid), 0);
    if (probe) begin
      chk("cfg_reopen", 32'(bus.cfg_ready), 1);
      @(negedge clk);
      bus.cfg_valid = 0;
      #1;
      chk("probe_err", 32'(err), 1);
    end
    @(negedge clk);
  endtask

  task automatic job(input logic [7:0] w, input int gap, input bit rnd, input int stall, input bit probe);
    longint s;
    int e0, b0, r0, l0;
    s = 0;
    foreach (acts[i]) s += longint'(w) * longint'(acts[i]);
    e0 = en_cnt; b0 = busy_cnt; r0 = rv_cnt; l0 = wl_cnt;
    accept(w, acts.size());
    feed(gap, rnd);
    finish(24'(s), stall, probe);
    d_en = en_cnt - e0; d_busy = busy_cnt - b0; d_rv = rv_cnt - r0; d_wl = wl_cnt - l0;
    chk("en_beats", 32'(d_en), 32'(acts.size()));
    chk("w_loads", 32'(d_wl), 1);
  endtask

  initial begin
    int e0, b0, l0, r0;
    bus.cfg_valid = 0; bus.cfg_len = 0; bus.cfg_weight = 0;
    bus.act_valid = 0; bus.act_data = 0; bus.res_ready = 0;
    repeat (2) @(negedge clk);
    #1;
    chk_quiet("reset");
    @(negedge clk);
    rst = 0;

    acts = '{8'd1, 8'd2, 8'd3, 8'd4};
    job(8'd3, 0, 0, 0, 0);
    chk("basic_job_cycles", 32'(t1 - t0 + 1), 8);
    chk("basic_busy", 32'(d_busy), 7);
    chk("basic_res_valid_cycles", 32'(d_rv), 1);

    acts = '{8'd5, 8'd0, 8'd7};
    job(8'd2, 2, 0, 0, 0);

    acts = '{8'd1, 8'd2, 8'd3, 8'd4};
    job(8'd3, 0, 0, 5, 1);
    chk("stall_res_valid_cycles", 32'(d_rv), 6);

    e0 = en_cnt; b0 = busy_cnt; l0 = wl_cnt;
    bus.cfg_valid = 1; bus.cfg_len = 0; bus.cfg_weight = 8'd77;
    #1;
    chk("zero_cfg_ready", 32'(bus.cfg_ready), 1);
    @(negedge clk);
    bus.cfg_valid = 0;
    #1;
    chk("zero_err_pulse", 32'(err), 1);
    chk("zero_busy", 32'(busy), 0);
    @(negedge clk);
    #1;
    chk("zero_err_end", 32'(err), 0);
    @(negedge clk);
    chk("zero_no_strobes", 32'((en_cnt - e0) + (wl_cnt - l0) + (busy_cnt - b0)), 0);

    acts = '{8'd9, 8'd8, 8'd7, 8'd6};
    r0 = rv_cnt;
    accept(8'd4, 10);
    feed(0, 0);
    rst = 1;
    bus.act_valid = 1; bus.act_data = 8'd99;
    #1;
    chk_quiet("midrun_rst");
    @(negedge clk);
    rst = 0;
    bus.act_valid = 0; bus.act_data = 0;
    repeat (15) @(negedge clk);
    #1;
    chk("rst_no_result", 32'(rv_cnt - r0), 0);
    chk("rst_idle", 32'({busy, bus.cfg_ready}), 1);
    @(negedge clk);
    acts = '{8'd4, 8'd5};
    job(8'd1, 0, 0, 0, 0);

    acts = {};
    repeat (256) acts.push_back(8'd255);
    job(8'd255, 0, 0, 0, 0);

    repeat (6) begin
      int len;
      len = int'($urandom_range(1, 20));
      acts = {};
      repeat (len) acts.push_back(8'($urandom));
      job(8'($urandom), 0, 1, int'($urandom_range(0, 3)), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
